// File: rtl/pcma_eq_ctrl_if.sv
// Coefficient stream from the upstream coefficient source into the equalizer sequencer.
// Handshake: one word transfers on every rising clock edge where coe_vld and coe_rdy are
// both high. The source keeps coe_data stable and coe_vld high until the word is taken.
// The only exception is an aborted sequence, where the source may withdraw the word.
// coe_rdy may depend combinationally on the sink's own inputs but never on coe_vld.
interface pcma_eq_ctrl_if #(
  parameter int W = 24
);
  logic         coe_vld;
  logic [W-1:0] coe_data;
  logic         coe_rdy;

  modport master (output coe_vld, output coe_data, input coe_rdy);
  modport slave  (input coe_vld, input coe_data, output coe_rdy);
endinterface

// File: rtl/pcma_eq_ctrl.sv
// pcma_eq_ctrl: start/train/track sequencer for the PCMA complex LMS equalizer.
// IDLE -> PRESET or LOAD -> SETTLE -> TRAIN -> TRACK; i_stop returns to IDLE from any state.
// Optional macro PCMA_EQ_CTRL_TIMEOUT_EN adds a LOAD watchdog that aborts to IDLE and
// raises the sticky o_err flag after LOAD_TIMEOUT cycles without a coefficient handshake.
module pcma_eq_ctrl #(
  parameter int EQ_LEN         = 17,
  parameter int FULL_COE_WIDTH = 24,
  parameter int NORM_WIDTH     = 10
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
  ,
  parameter int LOAD_TIMEOUT   = 1023
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic                      i_stop,
  input  logic [7:0]                i_settle_len,
  input  logic [15:0]               i_train_len,
  input  logic [NORM_WIDTH-1:0]     i_train_norm,
  input  logic [NORM_WIDTH-1:0]     i_track_norm,
  pcma_eq_ctrl_if.slave             s_coe,
  input  logic                      i_sym_vld,
  output logic                      o_preset_coe,
  output logic                      o_load_coe,
  output logic [FULL_COE_WIDTH-1:0] o_init_coe,
  output logic                      o_teach_en,
  output logic [NORM_WIDTH-1:0]     o_norm_per,
  output logic [2:0]                o_state,
  output logic                      o_trained,
  output logic                      o_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_TRAIN  = 3'd4,
    ST_TRACK  = 3'd5
  } state_t;

  localparam int BEAT_W = (EQ_LEN > 1) ? $clog2(EQ_LEN + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(EQ_LEN - 1);

  state_t                state;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [15:0]           sym_cnt;
  logic [15:0]           sym_nxt;
  logic [7:0]            settle_len;
  logic [15:0]           train_len;
  logic [NORM_WIDTH-1:0] train_norm;
  logic [NORM_WIDTH-1:0] track_norm;
  logic                  coe_hs;

`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
  localparam int TO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
`else
  // Without the watchdog a load can never fail.
  assign o_err = 1'b0;
`endif

  // Ready only while loading; a stop request withdraws it in the same cycle.
  assign s_coe.coe_rdy = (state == ST_LOAD) && !i_stop;
  assign coe_hs        = s_coe.coe_vld && s_coe.coe_rdy;
  assign o_state       = state;

  // Symbol count that sticks at all-ones instead of wrapping.
  assign sym_nxt = (sym_cnt == 16'hFFFF) ? sym_cnt : sym_cnt + 16'd1;

  // Sequencer: state, symbol/beat counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      sym_cnt      <= '0;
      settle_len   <= '0;
      train_len    <= '0;
      train_norm   <= '0;
      track_norm   <= '0;
      o_preset_coe <= 1'b0;
      o_load_coe   <= 1'b0;
      o_init_coe   <= '0;
      o_teach_en   <= 1'b0;
      o_norm_per   <= '0;
      o_trained    <= 1'b0;
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
      to_cnt       <= '0;
      o_err        <= 1'b0;
`endif
    end else begin
      o_preset_coe <= 1'b0;
      o_load_coe   <= 1'b0;
      if (state != ST_IDLE && i_stop) begin
        // Freeze: adaptation off, coefficients and period left where they are.
        state      <= ST_IDLE;
        beat_cnt   <= '0;
        sym_cnt    <= '0;
        o_teach_en <= 1'b0;
        o_trained  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start && !i_stop) begin
              settle_len <= i_settle_len;
              train_len  <= i_train_len;
              train_norm <= i_train_norm;
              track_norm <= i_track_norm;
              beat_cnt   <= '0;
              sym_cnt    <= '0;
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
              to_cnt     <= '0;
              o_err      <= 1'b0;
`endif
              if (i_mode) begin
                state <= ST_LOAD;
              end else begin
                state        <= ST_PRESET;
                o_preset_coe <= 1'b1;
              end
            end
          end
          ST_PRESET: begin
            state   <= ST_SETTLE;
            sym_cnt <= '0;
          end
          ST_LOAD: begin
            if (coe_hs) begin
              o_load_coe <= 1'b1;
              o_init_coe <= s_coe.coe_data;
              if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                sym_cnt  <= '0;
                state    <= ST_SETTLE;
              end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
              end
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
              to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              to_cnt   <= '0;
              beat_cnt <= '0;
              o_err    <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
`endif
            end
          end
          ST_SETTLE: begin
            if (settle_len == 8'd0) begin
              state      <= ST_TRAIN;
              sym_cnt    <= '0;
              o_teach_en <= 1'b1;
              o_norm_per <= train_norm;
            end else if (i_sym_vld) begin
              if (sym_nxt == {8'd0, settle_len}) begin
                state      <= ST_TRAIN;
                sym_cnt    <= '0;
                o_teach_en <= 1'b1;
                o_norm_per <= train_norm;
              end else begin
                sym_cnt <= sym_nxt;
              end
            end
          end
          ST_TRAIN: begin
            if (train_len == 16'd0) begin
              state      <= ST_TRACK;
              sym_cnt    <= '0;
              o_norm_per <= track_norm;
              o_trained  <= 1'b1;
            end else if (i_sym_vld) begin
              if (sym_nxt == train_len) begin
                state      <= ST_TRACK;
                sym_cnt    <= '0;
                o_norm_per <= track_norm;
                o_trained  <= 1'b1;
              end else begin
                sym_cnt <= sym_nxt;
              end
            end
          end
          ST_TRACK: begin
            if (i_sym_vld) begin
              sym_cnt <= sym_nxt;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcma_eq_ctrl.sv
// Bench for pcma_eq_ctrl: reset values, a table of IDLE commands, directed multi-cycle
// sequences and randomized runs checked against a timeline model built from the symbol and
// valid patterns. Define PCMA_EQ_CTRL_TIMEOUT_EN to also exercise the LOAD watchdog.
module tb_pcma_eq_ctrl;
  localparam int EQ_LEN = 17;
  localparam int CW     = 24;
  localparam int NW     = 10;
  localparam int MAXC   = 600;
  localparam int NEVER  = 1 << 30;
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
  localparam int TO     = 8;
`endif
  localparam logic [2:0] S_IDLE = 3'd0, S_PRESET = 3'd1, S_LOAD = 3'd2,
                         S_SETTLE = 3'd3, S_TRAIN = 3'd4, S_TRACK = 3'd5;

  logic          clk;
  logic          reset_n;
  logic          i_start;
  logic          i_mode;
  logic          i_stop;
  logic [7:0]    i_settle_len;
  logic [15:0]   i_train_len;
  logic [NW-1:0] i_train_norm;
  logic [NW-1:0] i_track_norm;
  logic          i_sym_vld;
  logic          o_preset_coe;
  logic          o_load_coe;
  logic [CW-1:0] o_init_coe;
  logic          o_teach_en;
  logic [NW-1:0] o_norm_per;
  logic [2:0]    o_state;
  logic          o_trained;
  logic          o_err;

  pcma_eq_ctrl_if #(.W(CW)) coe_bus ();

  pcma_eq_ctrl #(
    .EQ_LEN(EQ_LEN),
    .FULL_COE_WIDTH(CW),
    .NORM_WIDTH(NW)
`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
    ,
    .LOAD_TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_stop(i_stop),
    .i_settle_len(i_settle_len),
    .i_train_len(i_train_len),
    .i_train_norm(i_train_norm),
    .i_track_norm(i_track_norm),
    .s_coe(coe_bus),
    .i_sym_vld(i_sym_vld),
    .o_preset_coe(o_preset_coe),
    .o_load_coe(o_load_coe),
    .o_init_coe(o_init_coe),
    .o_teach_en(o_teach_en),
    .o_norm_per(o_norm_per),
    .o_state(o_state),
    .o_trained(o_trained),
    .o_err(o_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests;
  int            n_fail;
  bit            sym_a[MAXC];
  bit            vld_a[MAXC];
  logic [CW-1:0] words[EQ_LEN+1];
  int            h[EQ_LEN];
  int            s0, t0, k0;
  logic [NW-1:0] prev_norm;
  logic [CW-1:0] prev_init;
  logic [CW-1:0] exp_q[$];

  typedef struct {
    bit         start;
    bit         mode;
    bit         stop;
    logic [2:0] exp_state;
    bit         exp_preset;
    bit         exp_rdy;
  } vec_t;
  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 1'b0;
    i_mode = 1'b0;
    i_stop = 1'b0;
    i_sym_vld = 1'b0;
    coe_bus.coe_vld = 1'b0;
    coe_bus.coe_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_state, S_IDLE);
    check({tag, "_preset"}, o_preset_coe, 0);
    check({tag, "_load"}, o_load_coe, 0);
    check({tag, "_init"}, o_init_coe, 0);
    check({tag, "_teach"}, o_teach_en, 0);
    check({tag, "_norm"}, o_norm_per, 0);
    check({tag, "_trained"}, o_trained, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_rdy"}, coe_bus.coe_rdy, 0);
  endtask

  // Cycle just after the n-th strobe counted from cycle 'from'; n == 0 moves on next cycle.
  function automatic int after_n(input int from, input int n);
    int k;
    k = 0;
    if (from >= NEVER) return NEVER;
    if (n == 0) return from + 1;
    for (int c = from; c < MAXC; c++) begin
      if (sym_a[c]) begin
        k++;
        if (k == n) return c + 1;
      end
    end
    return NEVER;
  endfunction

  // Timeline of one run (cycle 1 = first cycle after the accepted start).
  task automatic plan(input bit mode, input int sl, input int tl);
    int n;
    for (int k = 0; k < EQ_LEN; k++) h[k] = NEVER;
    if (!mode) begin
      s0 = 2;
    end else begin
      n = 0;
      s0 = NEVER;
      for (int c = 1; c < MAXC; c++) begin
        if (vld_a[c] && n < EQ_LEN) begin
          h[n] = c;
          n++;
          if (n == EQ_LEN) s0 = c + 1;
        end
      end
    end
    t0 = after_n(s0, sl);
    k0 = after_n(t0, tl);
  endtask

  function automatic logic [2:0] exp_st(input int c, input bit mode, input int stop_c);
    if (c < 1 || c > stop_c) return S_IDLE;
    if (c < s0) return mode ? S_LOAD : S_PRESET;
    if (c < t0) return S_SETTLE;
    if (c < k0) return S_TRAIN;
    return S_TRACK;
  endfunction

  // Valid pattern with random gaps of at most three cycles.
  task automatic gen_vld();
    int gap;
    gap = 0;
    for (int c = 0; c < MAXC; c++) begin
      vld_a[c] = (gap >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      gap = vld_a[c] ? 0 : gap + 1;
    end
  endtask

  // One start..stop run; i_stop is raised during cycle stop_c, so stop_c+1 must be IDLE.
  task automatic run(input bit mode, input logic [7:0] sl, input logic [15:0] tl,
                     input logic [NW-1:0] tn, input logic [NW-1:0] kn, input int stop_c);
    logic [NW-1:0] mnorm;
    logic [CW-1:0] minit;
    logic [2:0]    est;
    bit            eload;
    int            idx;
    int            qi;
    int            seen;
    mnorm = prev_norm;
    minit = prev_init;
    idx = 0;
    qi = 0;
    seen = 0;
    exp_q.delete();
    for (int k = 0; k < EQ_LEN; k++) if (h[k] < stop_c) exp_q.push_back(words[k]);
    i_start = 1'b1;
    i_mode = mode;
    i_stop = 1'b0;
    i_settle_len = sl;
    i_train_len = tl;
    i_train_norm = tn;
    i_track_norm = kn;
    i_sym_vld = 1'b0;
    coe_bus.coe_vld = 1'b0;
    step();
    for (int c = 1; c <= stop_c + 1; c++) begin
      est = exp_st(c, mode, stop_c);
      if (est == S_TRAIN) mnorm = tn;
      else if (est == S_TRACK) mnorm = kn;
      eload = (qi < EQ_LEN) && (exp_q.size() > 0) && (c == h[qi] + 1);
      check("state", o_state, est);
      check("teach_en", o_teach_en, (est == S_TRAIN || est == S_TRACK));
      check("trained", o_trained, (est == S_TRACK));
      check("norm_per", o_norm_per, mnorm);
      check("preset_coe", o_preset_coe, (c == 1 && !mode));
      check("err", o_err, 0);
      check("load_coe", o_load_coe, eload);
      if (o_load_coe) seen++;
      if (eload) begin
        minit = exp_q.pop_front();
        qi++;
      end
      check("init_coe", o_init_coe, minit);
      if (c == stop_c + 1) break;
      // Mid-run commands and config changes must all be ignored.
      i_start = 1'($urandom_range(0, 1));
      i_mode = 1'($urandom_range(0, 1));
      i_settle_len = 8'($urandom);
      i_train_len = 16'($urandom);
      i_train_norm = NW'($urandom);
      i_track_norm = NW'($urandom);
      i_stop = (c == stop_c);
      i_sym_vld = sym_a[c];
      if (mode && ((idx < EQ_LEN) ? vld_a[c] : 1'b1)) begin
        coe_bus.coe_vld = 1'b1;
        coe_bus.coe_data = words[idx];
        if (est == S_LOAD && c != stop_c) idx++;
      end else begin
        coe_bus.coe_vld = 1'b0;
      end
      #1;
      check("s_coe_rdy", coe_bus.coe_rdy, (est == S_LOAD && c != stop_c));
      step();
    end
    check("load_pulses", seen, qi);
    idle_inputs();
    prev_norm = mnorm;
    prev_init = minit;
  endtask

  initial begin
    int stop_c;
    int lim;
    bit mode;
    int sl;
    int tl;
    n_tests = 0;
    n_fail = 0;
    prev_norm = '0;
    prev_init = '0;
    idle_inputs();
    i_settle_len = 8'd3;
    i_train_len = 16'd5;
    i_train_norm = 10'd1;
    i_track_norm = 10'd2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset_n = 1'b1;
    step();
    check_all_zero("after_reset");

    // IDLE command table: stop always beats start.
    vec[0] = '{start: 0, mode: 0, stop: 0, exp_state: S_IDLE,   exp_preset: 0, exp_rdy: 0};
    vec[1] = '{start: 1, mode: 0, stop: 1, exp_state: S_IDLE,   exp_preset: 0, exp_rdy: 0};
    vec[2] = '{start: 1, mode: 1, stop: 1, exp_state: S_IDLE,   exp_preset: 0, exp_rdy: 0};
    vec[3] = '{start: 0, mode: 1, stop: 1, exp_state: S_IDLE,   exp_preset: 0, exp_rdy: 0};
    vec[4] = '{start: 1, mode: 0, stop: 0, exp_state: S_PRESET, exp_preset: 1, exp_rdy: 0};
    vec[5] = '{start: 1, mode: 1, stop: 0, exp_state: S_LOAD,   exp_preset: 0, exp_rdy: 1};
    for (int r = 0; r < 6; r++) begin
      i_start = vec[r].start;
      i_mode = vec[r].mode;
      i_stop = vec[r].stop;
      step();
      i_start = 1'b0;
      i_stop = 1'b0;
      #1;
      check("vec_state", o_state, vec[r].exp_state);
      check("vec_preset", o_preset_coe, vec[r].exp_preset);
      check("vec_rdy", coe_bus.coe_rdy, vec[r].exp_rdy);
      if (vec[r].exp_state != S_IDLE) begin
        i_stop = 1'b1;
        #1;
        check("vec_rdy_stop", coe_bus.coe_rdy, 0);
        step();
        i_stop = 1'b0;
        check("vec_back_idle", o_state, S_IDLE);
      end
    end

    // Preset, strobe every 4th cycle, full training then tracking.
    for (int c = 0; c < MAXC; c++) sym_a[c] = (c % 4 == 0);
    plan(1'b0, 4, 100);
    run(1'b0, 8'd4, 16'd100, 10'd16, 10'd512, k0 + 10);

    // Stop during TRAIN on the 50th strobe, then a fresh preset start.
    plan(1'b0, 4, 100);
    run(1'b0, 8'd4, 16'd100, 10'd16, 10'd512, after_n(t0, 50) - 1);
    plan(1'b0, 1, 2);
    run(1'b0, 8'd1, 16'd2, 10'd33, 10'd44, k0 + 3);

    // Zero settle and train lengths: one cycle each.
    plan(1'b0, 0, 0);
    run(1'b0, 8'd0, 16'd0, 10'd7, 10'd9, 8);

    // Load 1..17 with gaps; word 18 offered afterwards.
    for (int k = 0; k <= EQ_LEN; k++) words[k] = CW'(k + 1);
    gen_vld();
    for (int c = 0; c < MAXC; c++) sym_a[c] = 1'($urandom_range(0, 1));
    plan(1'b1, 2, 3);
    run(1'b1, 8'd2, 16'd3, 10'd100, 10'd200, k0 + 6);

    // Randomized runs, stop anywhere from cycle 2 on.
    for (int r = 0; r < 14; r++) begin
      mode = 1'($urandom_range(0, 1));
      sl = $urandom_range(0, 5);
      tl = $urandom_range(0, 8);
      for (int k = 0; k <= EQ_LEN; k++) words[k] = CW'($urandom);
      gen_vld();
      for (int c = 0; c < MAXC; c++) sym_a[c] = ($urandom_range(0, 2) == 0);
      plan(mode, sl, tl);
      lim = (k0 < MAXC - 20) ? k0 + 8 : MAXC - 20;
      stop_c = $urandom_range(2, lim);
      run(mode, 8'(sl), 16'(tl), NW'($urandom), NW'($urandom), stop_c);
    end

`ifdef PCMA_EQ_CTRL_TIMEOUT_EN
    // Watchdog: 5 words, then silence for TO cycles.
    i_start = 1'b1;
    i_mode = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      coe_bus.coe_vld = 1'b1;
      coe_bus.coe_data = CW'(i + 1);
      step();
    end
    coe_bus.coe_vld = 1'b0;
    for (int i = 0; i < TO - 1; i++) step();
    check("to_still_load", o_state, S_LOAD);
    check("to_err_low", o_err, 0);
    step();
    check("to_idle", o_state, S_IDLE);
    check("to_err_set", o_err, 1);
    step();
    check("to_err_sticky", o_err, 1);
    i_start = 1'b1;
    i_mode = 1'b0;
    step();
    i_start = 1'b0;
    check("to_restart_state", o_state, S_PRESET);
    check("to_err_cleared", o_err, 0);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("to_stop_idle", o_state, S_IDLE);
    prev_init = CW'(5);
`endif

    // Asynchronous reset in the middle of a load.
    i_start = 1'b1;
    i_mode = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coe_bus.coe_vld = 1'b1;
      coe_bus.coe_data = CW'(24'hABC000 + i);
      step();
    end
    check("rst_pre_state", o_state, S_LOAD);
    check("rst_pre_load", o_load_coe, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_load_reset");
    idle_inputs();
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_state", o_state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcma_eq_ctrl.md
Name: pcma_eq_ctrl

Overview:
Sequencer for the PCMA complex LMS equalizer: it starts the equalizer, trains it and keeps it tracking.
- On command it either presets the coefficients to a centre tap or streams EQ_LEN coefficients from an upstream valid/ready source.
- It then waits for the pipeline to fill, runs a training window with a fast normalisation period, and switches to tracking with a slow period.
- It sits between the modem control registers and the equalizer's preset_coe/load_coe/i_init_coe/teach_en/i_norm_per inputs, and counts symbols on the equalizer's output strobe.

Parameters:
- EQ_LEN, 17, number of coefficients loaded per LOAD sequence.
- FULL_COE_WIDTH, 24, coefficient word width (visible + invisible part).
- NORM_WIDTH, 10, normalisation period width.
- LOAD_TIMEOUT, 1023, cycles without a handshake before LOAD aborts (used only with the macro).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start command.
- i_mode  in  1  0 = preset, 1 = load; sampled with i_start.
- i_stop  in  1  abort/freeze command, level or pulse.
- i_settle_len  in  8  settle length in symbols; sampled at start.
- i_train_len  in  16  training length in symbols; sampled at start.
- i_train_norm  in  NORM_WIDTH  normalisation period during TRAIN; sampled at start.
- i_track_norm  in  NORM_WIDTH  normalisation period during TRACK; sampled at start.
- s_coe_vld  in  1  upstream coefficient valid.
- s_coe_data  in  FULL_COE_WIDTH  upstream coefficient word.
- s_coe_rdy  out  1  coefficient ready.
- i_sym_vld  in  1  equalizer output symbol strobe.
- o_preset_coe  out  1  preset pulse to the equalizer.
- o_load_coe  out  1  load strobe to the equalizer.
- o_init_coe  out  FULL_COE_WIDTH  coefficient word to the equalizer.
- o_teach_en  out  1  LMS adaptation enable.
- o_norm_per  out  NORM_WIDTH  normalisation period to the equalizer.
- o_state  out  3  current state: IDLE=0, PRESET=1, LOAD=2, SETTLE=3, TRAIN=4, TRACK=5.
- o_trained  out  1  high while in TRACK.
- o_err  out  1  sticky load-timeout flag.

Behaviour:
- Reset (asynchronous, active-low): all registered outputs are 0, o_state=IDLE, all counters 0.
- All outputs are registered except s_coe_rdy, which is combinational: s_coe_rdy = (state==LOAD) && !i_stop.
- i_start is accepted only in IDLE with i_stop low. Start and stop in the same cycle: stop wins and start is ignored.
- On accept: latch the four config inputs, clear o_err.
  - i_mode=0: go to PRESET.
  - i_mode=1: go to LOAD.
- PRESET:
  - o_preset_coe=1 for exactly one cycle, in the cycle after the accept.
  - Next state SETTLE.
- LOAD:
  - Each handshake (s_coe_vld && s_coe_rdy) drives o_load_coe=1 and o_init_coe=s_coe_data on the next cycle; beat counter increments.
  - o_init_coe holds its last value between beats.
  - On the EQ_LEN-th handshake, go to SETTLE; s_coe_rdy is low from the next cycle, so beat EQ_LEN+1 is never accepted.
  - Gaps in s_coe_vld are allowed; the counter simply holds.
- SETTLE:
  - o_teach_en=0.
  - Count i_sym_vld strobes; go to TRAIN on the strobe that makes count == settle_len.
  - settle_len=0: go to TRAIN on the next cycle.
- TRAIN:
  - o_teach_en=1, o_norm_per=train_norm.
  - Count i_sym_vld strobes; go to TRACK when count == train_len.
  - train_len=0: go to TRACK on the next cycle.
- TRACK:
  - o_teach_en=1, o_norm_per=track_norm, o_trained=1.
  - Remains in TRACK until i_stop.
- i_stop in any non-IDLE state: IDLE on the next cycle.
  - o_teach_en, o_trained, o_load_coe and o_preset_coe are 0 from that cycle.
  - o_norm_per holds its value; the equalizer coefficients are frozen. A partial load is left as is.
- The symbol counter is 16 bits, clears on every state change and saturates at all-ones.
- Config inputs changing mid-run have no effect until the next accepted start.

Optional Feature:
- Macro: PCMA_EQ_CTRL_TIMEOUT_EN.
- Defined:
  - In LOAD, a cycle counter clears on each handshake.
  - When it reaches LOAD_TIMEOUT cycles without a handshake: go to IDLE and set o_err=1. o_err stays set until the next accepted start.
- Not defined: LOAD waits indefinitely; o_err is tied to 0; no timeout counter is synthesised.

Test Plan:
- Preset with settle_len=4, train_len=100, train_norm=16, track_norm=512; i_sym_vld every 4th cycle.
  - o_preset_coe is high exactly in the cycle after start.
  - o_teach_en rises after the 4th strobe.
  - o_norm_per=16 for 100 strobes, then 512.
  - o_trained=1 after that.
- Load with EQ_LEN=17, words 0x000001..0x000011, random s_coe_vld gaps.
  - Exactly 17 o_load_coe pulses, each carrying the matching word.
  - The 18th offered word is not accepted (s_coe_rdy low).
- i_stop asserted during TRAIN at strobe 50.
  - Next cycle: state IDLE, o_teach_en=0, o_norm_per still 16.
  - A following i_start with i_mode=0 is accepted.
- i_start and i_stop asserted in the same IDLE cycle: no state change. Separately, i_start during TRACK is ignored.
- settle_len=0, train_len=0, preset mode: sequence PRESET -> SETTLE -> TRAIN -> TRACK, one cycle each.
- With PCMA_EQ_CTRL_TIMEOUT_EN, LOAD_TIMEOUT=8, s_coe_vld stopped after 5 words.
  - After 8 idle cycles: state IDLE, o_err=1.
  - Next start clears o_err.
  - Assert reset_n low mid-LOAD: all outputs 0 immediately.
